// File: rtl/bpred_pkg.sv
// Shared types and row packing helpers for the perceptron predictor weight tables.
// A row stores the 3-bit high parts of all weights above the 5-bit low parts.
package bpred_pkg;
    localparam int GHR_SIZE = 12;
    localparam int WEIGHT_W = 8;
    localparam int HOB_W    = 3;
    localparam int LOB_W    = 5;
    localparam int ROW_W    = 96;
    localparam int IDX_W    = 6;
    localparam int SUM_W    = 7;

    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef logic [GHR_SIZE-1:0][WEIGHT_W-1:0] weight_vec_t;
    typedef logic [ROW_W-1:0] row_t;

    function automatic weight_vec_t unpack_row(input row_t row);
        weight_vec_t w;
        for (int i = 0; i < GHR_SIZE; i++) begin
            w[i] = {row[GHR_SIZE*LOB_W + HOB_W*i +: HOB_W], row[LOB_W*i +: LOB_W]};
        end
        return w;
    endfunction

    function automatic row_t pack_row(input weight_vec_t w);
        row_t r;
        r = '0;
        for (int i = 0; i < GHR_SIZE; i++) begin
            r[LOB_W*i +: LOB_W]                   = w[i][LOB_W-1:0];
            r[GHR_SIZE*LOB_W + HOB_W*i +: HOB_W] = w[i][WEIGHT_W-1:LOB_W];
        end
        return r;
    endfunction
endpackage

// File: rtl/sat_weight_step.sv
// One perceptron weight nudged by +1 or -1, clamped to the signed weight range.
module sat_weight_step
    import bpred_pkg::*;
(
    input  weight_t weight,
    input  logic    inc,
    output weight_t result
);
    localparam weight_t W_MAX = 8'sh7F;
    localparam weight_t W_MIN = 8'sh80;
    localparam weight_t ONE   = 8'sh01;

    always_comb begin
        result = weight;
        if (inc) begin
            if (weight != W_MAX) begin
                result = weight + ONE;
            end
        end else if (weight != W_MIN) begin
            result = weight - ONE;
        end
    end
endmodule

// File: rtl/perceptron_update_unit.sv
// Perceptron training stage: registers resolved branches, applies the saturating update
// rule and buffers trained rows in a small FIFO in front of the weight-table write port.
module perceptron_update_unit
    import bpred_pkg::*;
#(
    parameter int THETA  = 7,
    parameter int QDEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                execute_bpredictor_update,
    input  logic [31:0]         execute_bpredictor_PC4,
    input  logic                execute_bpredictor_dir,
    input  logic                execute_bpredictor_miss,
    input  logic [GHR_SIZE-1:0] execute_ghr,
    input  logic [SUM_W-1:0]    execute_sum,
    input  logic [ROW_W-1:0]    execute_weights,
    input  logic                soin_bpredictor_stall,
    output logic                up_wen,
    output logic [IDX_W-1:0]    up_addr,
    output logic [ROW_W-1:0]    up_data,
    output logic                up_drop,
    output logic [31:0]         train_count,
    output logic [31:0]         drop_count
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SUM_W:0] THETA_V = (SUM_W+1)'(THETA);

    // Input decode
    logic [31:0]      pc_m4;
    logic [IDX_W-1:0] in_idx;
    logic [SUM_W:0]   sum_ext;
    logic [SUM_W:0]   abs_sum;
    logic             in_train;
    logic             unused_pc_bits;

    assign pc_m4          = execute_bpredictor_PC4 - 32'd4;
    assign in_idx         = pc_m4[IDX_W+1:2];
    assign unused_pc_bits = ^{pc_m4[31:IDX_W+2], pc_m4[1:0]};
    assign sum_ext        = {execute_sum[SUM_W-1], execute_sum};
    assign abs_sum        = sum_ext[SUM_W] ? ((SUM_W+1)'(0) - sum_ext) : sum_ext;
    assign in_train       = execute_bpredictor_miss | (abs_sum <= THETA_V);

    // S1 registers
    logic                s1_valid_reg;
    logic                s1_train_reg;
    logic                s1_dir_reg;
    logic [GHR_SIZE-1:0] s1_ghr_reg;
    logic [IDX_W-1:0]    s1_idx_reg;
    weight_vec_t         s1_weights_reg;

    // S2 combinational update
    weight_vec_t s2_weights;
    row_t        s2_row;

    generate
        for (genvar gi = 0; gi < GHR_SIZE; gi++) begin : g_step
            sat_weight_step u_step (
                .weight (s1_weights_reg[gi]),
                .inc    (s1_dir_reg == s1_ghr_reg[gi]),
                .result (s2_weights[gi])
            );
        end
    endgenerate

    assign s2_row = pack_row(s2_weights);

    // A back-to-back update to the same row must build on the row still in flight.
    logic        fwd;
    weight_vec_t in_weights;

    assign fwd        = s1_valid_reg & s1_train_reg & (s1_idx_reg == in_idx);
    assign in_weights = fwd ? s2_weights : unpack_row(execute_weights);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg   <= 1'b0;
            s1_train_reg   <= 1'b0;
            s1_dir_reg     <= 1'b0;
            s1_ghr_reg     <= '0;
            s1_idx_reg     <= '0;
            s1_weights_reg <= '0;
        end else begin
            s1_valid_reg <= execute_bpredictor_update;
            if (execute_bpredictor_update) begin
                s1_train_reg   <= in_train;
                s1_dir_reg     <= execute_bpredictor_dir;
                s1_ghr_reg     <= execute_ghr;
                s1_idx_reg     <= in_idx;
                s1_weights_reg <= in_weights;
            end
        end
    end

    // Pending-write queue
    logic [IDX_W-1:0] q_addr_reg [QDEPTH];
    row_t             q_data_reg [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             q_empty;
    logic             q_full;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;

    assign q_empty  = (count_reg == '0);
    assign q_full   = (count_reg == CNT_W'(QDEPTH));
    assign pop      = ~q_empty & ~soin_bpredictor_stall;
    assign push_req = s1_valid_reg & s1_train_reg;
    assign push     = push_req & (~q_full | pop);
    assign drop     = push_req & q_full & ~pop;

    assign up_wen  = pop;
    assign up_addr = q_addr_reg[rd_ptr_reg];
    assign up_data = q_data_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_addr_reg[i] <= '0;
                q_data_reg[i] <= '0;
            end
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                q_addr_reg[wr_ptr_reg] <= s1_idx_reg;
                q_data_reg[wr_ptr_reg] <= s2_row;
                wr_ptr_reg             <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Statistics
    logic        up_drop_reg;
    logic [31:0] train_count_reg;
    logic [31:0] drop_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_drop_reg     <= 1'b0;
            train_count_reg <= '0;
            drop_count_reg  <= '0;
        end else begin
            up_drop_reg <= drop;
            if (push_req) begin
                train_count_reg <= train_count_reg + 32'd1;
            end
            if (drop) begin
                drop_count_reg <= drop_count_reg + 32'd1;
            end
        end
    end

    assign up_drop     = up_drop_reg;
    assign train_count = train_count_reg;
    assign drop_count  = drop_count_reg;
endmodule
